// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and sizes for the MEM pipeline stage
package mem_stage_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  typedef enum logic {IDLE, ACCESS} state_e;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [REG_ADDR_W-1:0] rd;
    logic wb;
    logic is_byte;
    logic we;
  } req_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects doubleword or zero-extended byte load data
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic            en_i,
  input  logic            is_load_i,
  input  logic            is_byte_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);
  assign data_o = !(en_i && is_load_i) ? '0 :
                  is_byte_i ? {{(XLEN-8){1'b0}}, rdata_i[7:0]} : rdata_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with stalling data-memory handshake and timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  xfer_byte,
  input  logic [XLEN-1:0]       ALUresult,
  input  logic [XLEN-1:0]       store_data,
  input  logic [REG_ADDR_W-1:0] Rd,
  input  logic                  WB,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  dmem_byte,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic [XLEN-1:0]       Mem_out,
  output logic [XLEN-1:0]       ALUresult_out,
  output logic [REG_ADDR_W-1:0] Rd_out,
  output logic                  WB_out,
  output logic                  out_valid,
  output logic                  stall,
  output logic                  mem_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  req_t req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic ack, to, vld, stl, wb;
  // next-state and handshake decode; ack beats timeout in the same cycle
  always_comb begin
    ack = state_q == ACCESS && dmem_ack;
    to = state_q == ACCESS && !dmem_ack && cnt_q == CW'(TIMEOUT_CYCLES);
    state_d = state_q;
    req_d = req_q;
    cnt_d = cnt_q;
    err_d = err_q | to;
    vld = 1'b0;
    stl = 1'b0;
    wb = 1'b0;
    if (state_q == IDLE) begin
      vld = in_valid && !(mem_read || mem_write);
      stl = in_valid && (mem_read || mem_write);
      wb = vld && WB;
      if (stl) begin
        req_d = '{addr: ALUresult, wdata: store_data, rd: Rd, wb: WB, is_byte: xfer_byte, we: mem_write};
        cnt_d = '0;
        state_d = ACCESS;
      end
    end else begin
      vld = ack || to;
      stl = !vld;
      wb = ack && req_q.wb;
      cnt_d = vld ? '0 : cnt_q + 1'b1;
      state_d = vld ? IDLE : ACCESS;
    end
  end
  // state, latched request, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  mem_load_align u_align (
    .en_i     (ack),
    .is_load_i(!req_q.we),
    .is_byte_i(req_q.is_byte),
    .rdata_i  (dmem_rdata),
    .data_o   (Mem_out)
  );
  assign dmem_req = state_q == ACCESS;
  assign dmem_we = req_q.we;
  assign dmem_byte = req_q.is_byte;
  assign dmem_addr = req_q.addr;
  assign dmem_wdata = req_q.wdata;
  assign ALUresult_out = state_q == IDLE ? ALUresult : req_q.addr;
  assign Rd_out = state_q == IDLE ? Rd : req_q.rd;
  assign out_valid = vld & ~rst;
  assign stall = stl & ~rst;
  assign WB_out = wb & ~rst;
  assign mem_err = err_q | to;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage
module tb_mem_stage;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic in_valid = 0, mem_read = 0, mem_write = 0, xfer_byte = 0, WB = 0;
  logic [63:0] ALUresult = 0, store_data = 0, dmem_rdata = 0;
  logic [4:0] Rd = 0;
  logic dmem_ack = 0;
  logic dmem_req, dmem_we, dmem_byte, WB_out, out_valid, stall, mem_err;
  logic [63:0] dmem_addr, dmem_wdata, Mem_out, ALUresult_out;
  logic [4:0] Rd_out;
  typedef struct {logic [63:0] alu; logic [4:0] rd; logic wb; logic [63:0] mem;} exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  bit err_m = 0;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .xfer_byte(xfer_byte), .ALUresult(ALUresult), .store_data(store_data), .Rd(Rd), .WB(WB),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_byte(dmem_byte), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .Mem_out(Mem_out),
    .ALUresult_out(ALUresult_out), .Rd_out(Rd_out), .WB_out(WB_out), .out_valid(out_valid),
    .stall(stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endfunction

  function automatic logic [63:0] load_val(bit byt, logic [63:0] r);
    return byt ? (r & 64'hFF) : r;
  endfunction

  // monitor: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_alu", ALUresult_out, e.alu);
        chk("mon_rd", Rd_out, e.rd);
        chk("mon_wb", WB_out, e.wb);
        chk("mon_mem", Mem_out, e.mem);
      end
    end
  end

  task automatic op(input bit mr, mw, byt, input logic [63:0] a, sd, input logic [4:0] r,
                    input bit wb, input int dly, input logic [63:0] rdat);
    exp_t e;
    in_valid = 1; mem_read = mr; mem_write = mw; xfer_byte = byt;
    ALUresult = a; store_data = sd; Rd = r; WB = wb; dmem_ack = 0;
    if (!(mr || mw)) begin
      e = '{a, r, wb, 64'd0};
      q.push_back(e);
      @(negedge clk);
      chk("alu_stall", stall, 0);
      chk("alu_req", dmem_req, 0);
      @(posedge clk); #1 in_valid = 0;
      return;
    end
    if (dly > TO) e = '{a, r, 1'b0, 64'd0};
    else e = '{a, r, wb, mw ? 64'd0 : load_val(byt, rdat)};
    q.push_back(e);
    @(negedge clk);
    chk("accept_stall", stall, 1);
    @(posedge clk); #1;
    in_valid = 0; mem_read = 1'($urandom); mem_write = 1'($urandom); xfer_byte = 1'($urandom);
    ALUresult = {$urandom, $urandom}; store_data = {$urandom, $urandom}; Rd = 5'($urandom); WB = 1'($urandom);
    for (int i = 0; i <= TO; i++) begin
      dmem_ack = (i == dly);
      dmem_rdata = (i == dly) ? rdat : {$urandom, $urandom};
      @(negedge clk);
      chk("req", dmem_req, 1);
      chk("addr", dmem_addr, a);
      chk("we", dmem_we, mw);
      chk("byte", dmem_byte, byt);
      chk("wdata", dmem_wdata, sd);
      if (i == dly || i == TO) begin
        chk("done_stall", stall, 0);
        if (i != dly) err_m = 1;
        chk("mem_err", mem_err, err_m);
        @(posedge clk); #1 dmem_ack = 0;
        break;
      end
      chk("wait_stall", stall, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("req_drop", dmem_req, 0);
    chk("idle_wb", WB_out, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", mem_err, 0);
    @(posedge clk); #1;
    op(0, 0, 0, 64'h10, 64'h0, 5'd3, 1, 0, 64'h0);
    op(1, 0, 0, 64'h40, 64'h0, 5'd7, 1, 2, 64'hDEADBEEFCAFEF00D);
    op(1, 0, 1, 64'h41, 64'h0, 5'd9, 1, 0, 64'hFFFFFFFFFFFFFF80);
    op(0, 1, 1, 64'h80, 64'h1234, 5'd0, 0, 1, 64'h0);
    op(1, 1, 0, 64'h88, 64'h55AA, 5'd4, 0, 3, 64'h0);
    op(1, 0, 0, 64'h90, 64'h0, 5'd5, 1, 4, 64'h0123456789ABCDEF);
    op(1, 0, 0, 64'h98, 64'h0, 5'd6, 1, 5, 64'h0);
    chk("err_sticky", mem_err, 1);
    op(0, 0, 0, 64'h20, 64'h0, 5'd8, 1, 0, 64'h0);
    in_valid = 1; mem_read = 1; mem_write = 0; ALUresult = 64'hA0; Rd = 5'd2; WB = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; err_m = 0;
    @(negedge clk);
    chk("rsta_req", dmem_req, 0);
    chk("rsta_stall", stall, 0);
    chk("rsta_valid", out_valid, 0);
    chk("rsta_err", mem_err, 0);
    @(posedge clk); #1 dmem_ack = 1; dmem_rdata = 64'h1;
    @(negedge clk);
    chk("late_ack_valid", out_valid, 0);
    chk("late_ack_req", dmem_req, 0);
    @(posedge clk); #1 dmem_ack = 0;
    for (int k = 0; k < 40; k++)
      op(1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
         5'($urandom), 1'($urandom), $urandom_range(0, 6), {$urandom, $urandom});
    repeat (2) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
